// File: rtl/hazard_ctrl_if.sv
// Hazard control interface: bundles the pipeline-side hazard inputs and the
// stall/flush controls of hazard_ctrl.
//   master : pipeline side, drives hazard inputs, observes stall/flush controls
//   slave  : hazard_ctrl side, observes hazard inputs, drives controls and counter
// Parameters: RW = register index width, CNT_W = stall counter width.
interface hazard_ctrl_if #(
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [RW-1:0]    IDEX_rt;
  logic [RW-1:0]    IFID_rs;
  logic [RW-1:0]    IFID_rt;
  logic             IFID_use_rs;
  logic             IFID_use_rt;
  logic             IFID_mdu;
  logic             mdu_start;
  logic             EXMEM_MemAcc;
  logic             mem_ready;
  logic             branch_taken;
  logic             pc_stall;
  logic             IFID_stall;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             EXMEM_stall;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
           IFID_mdu, mdu_start, EXMEM_MemAcc, mem_ready, branch_taken,
    input  pc_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall, stall_cycles
  );

  modport slave (
    input  IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt,
           IFID_mdu, mdu_start, EXMEM_MemAcc, mem_ready, branch_taken,
    output pc_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Detects load-use hazards, multiply/divide unit
// busy hazards and data-memory wait states, and resolves them together with
// taken branches into PC/IF-ID/EX-MEM stalls and IF-ID/ID-EX flushes.
// Also counts cycles in which the PC is held (saturating).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; forces all controls to 0 while low
//   hz    : hazard_ctrl_if slave (hazard inputs, stall/flush outputs, counter)
// Parameters: RW register index width, MDU_LAT mult/div busy cycles (1..15),
//             CNT_W stall counter width.
module hazard_ctrl #(
  parameter int unsigned RW      = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  logic [RW-1:0]    ld_rt;
  logic             lu;
  logic             mem_wait;
  logic             mdu_busy;
  logic             mdu_hz;
  logic [3:0]       mdu_cnt;
  logic [CNT_W-1:0] stall_q;

  assign ld_rt = hz.IDEX_rt;

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign lu = hz.IDEX_MemRead && (ld_rt != '0) &&
              ((hz.IFID_use_rs && (hz.IFID_rs == ld_rt)) ||
               (hz.IFID_use_rt && (hz.IFID_rt == ld_rt)));

  assign mem_wait = hz.EXMEM_MemAcc && !hz.mem_ready;
  assign mdu_busy = (mdu_cnt != 4'd0);
  assign mdu_hz   = hz.IFID_mdu && mdu_busy;

  // A start seen during mem_wait is dropped: EX is frozen and the source
  // re-asserts it once the stall clears. A start while busy restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdu_cnt <= 4'd0;
    end else if (hz.mdu_start && !mem_wait) begin
      mdu_cnt <= 4'(MDU_LAT);
    end else if (mdu_busy) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end else begin
      mdu_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (hz.pc_stall && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_q;

  // Priority: mem_wait > (load-use | mdu) > branch. A branch coinciding with
  // any stall stays in ID and re-resolves, so it must not flush.
  always_comb begin
    hz.pc_stall    = 1'b0;
    hz.IFID_stall  = 1'b0;
    hz.IFID_flush  = 1'b0;
    hz.IDEX_flush  = 1'b0;
    hz.EXMEM_stall = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        hz.pc_stall    = 1'b1;
        hz.IFID_stall  = 1'b1;
        hz.EXMEM_stall = 1'b1;
      end else if (lu || mdu_hz) begin
        hz.pc_stall   = 1'b1;
        hz.IFID_stall = 1'b1;
        hz.IDEX_flush = 1'b1;
      end else if (hz.branch_taken) begin
        hz.IFID_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int unsigned RW      = 5;
  localparam int unsigned MDU_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RW(RW), .CNT_W(16)) hif ();
  hazard_ctrl_if #(.RW(RW), .CNT_W(4))  hif4 ();

  // The narrow-counter instance sees exactly the same stimulus.
  assign hif4.IDEX_MemRead = hif.IDEX_MemRead;
  assign hif4.IDEX_rt      = hif.IDEX_rt;
  assign hif4.IFID_rs      = hif.IFID_rs;
  assign hif4.IFID_rt      = hif.IFID_rt;
  assign hif4.IFID_use_rs  = hif.IFID_use_rs;
  assign hif4.IFID_use_rt  = hif.IFID_use_rt;
  assign hif4.IFID_mdu     = hif.IFID_mdu;
  assign hif4.mdu_start    = hif.mdu_start;
  assign hif4.EXMEM_MemAcc = hif.EXMEM_MemAcc;
  assign hif4.mem_ready    = hif.mem_ready;
  assign hif4.branch_taken = hif.branch_taken;

  hazard_ctrl #(.RW(RW), .MDU_LAT(MDU_LAT), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  hazard_ctrl #(.RW(RW), .MDU_LAT(MDU_LAT), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: time-stamp of the last accepted MDU start, and a plain
  // count of stalled cycles since reset.
  int cyc;
  int last_start;
  int scount;

  logic [4:0] last_outs;   // {pc_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall}
  logic [4:0] last_outs4;
  int         last_cnt;
  int         last_cnt4;

  typedef struct {
    logic       mr;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       mdu;
    logic       macc;
    logic       mrdy;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] model_outs();
    logic lu, mw, busy, hzd;
    lu = hif.IDEX_MemRead && (hif.IDEX_rt != 0) &&
         ((hif.IFID_use_rs && hif.IFID_rs == hif.IDEX_rt) ||
          (hif.IFID_use_rt && hif.IFID_rt == hif.IDEX_rt));
    mw   = hif.EXMEM_MemAcc && !hif.mem_ready;
    busy = (cyc - last_start >= 1) && (cyc - last_start <= int'(MDU_LAT));
    hzd  = lu || (hif.IFID_mdu && busy);
    if (!rst_n)    return 5'b00000;
    else if (mw)   return 5'b11001;
    else if (hzd)  return 5'b11010;
    else if (hif.branch_taken) return 5'b00100;
    else           return 5'b00000;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Sample mid-cycle, compare against the model, then advance one clock.
  task automatic step(input string tag);
    logic [4:0] e;
    #4;
    e = model_outs();
    last_outs  = {hif.pc_stall, hif.IFID_stall, hif.IFID_flush, hif.IDEX_flush, hif.EXMEM_stall};
    last_outs4 = {hif4.pc_stall, hif4.IFID_stall, hif4.IFID_flush, hif4.IDEX_flush,
                  hif4.EXMEM_stall};
    last_cnt   = int'(hif.stall_cycles);
    last_cnt4  = int'(hif4.stall_cycles);
    chk({tag, ".ctrl"}, 32'(last_outs), 32'(e));
    chk({tag, ".ctrl4"}, 32'(last_outs4), 32'(e));
    chk({tag, ".cnt"}, 32'(last_cnt), 32'(sat(scount, 65535)));
    chk({tag, ".cnt4"}, 32'(last_cnt4), 32'(sat(scount, 15)));
    @(posedge clk);
    if (!rst_n) begin
      last_start = -1000;
      scount     = 0;
    end else begin
      if (hif.mdu_start && !(hif.EXMEM_MemAcc && !hif.mem_ready)) last_start = cyc;
      if (e[4]) scount++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    hif.IDEX_MemRead = 1'b0;
    hif.IDEX_rt      = '0;
    hif.IFID_rs      = '0;
    hif.IFID_rt      = '0;
    hif.IFID_use_rs  = 1'b0;
    hif.IFID_use_rt  = 1'b0;
    hif.IFID_mdu     = 1'b0;
    hif.mdu_start    = 1'b0;
    hif.EXMEM_MemAcc = 1'b0;
    hif.mem_ready    = 1'b0;
    hif.branch_taken = 1'b0;
  endtask

  task automatic set_lu(input logic on);
    hif.IDEX_MemRead = on;
    hif.IDEX_rt      = 5'd8;
    hif.IFID_rs      = 5'd8;
    hif.IFID_use_rs  = on;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("rst");
    rst_n = 1'b1;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 5'b11010};  // load-use via rs
    vecs[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000};  // r0 never hazards
    vecs[2]  = '{1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 5'b00000};  // rt match, not used
    vecs[3]  = '{1, 9, 0, 9, 0, 1, 0, 0, 0, 0, 5'b11010};  // load-use via rt
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00100};  // branch alone
    vecs[5]  = '{1, 8, 8, 0, 1, 0, 0, 0, 0, 1, 5'b11010};  // lu beats branch
    vecs[6]  = '{1, 8, 8, 0, 1, 0, 0, 1, 0, 1, 5'b11001};  // mem_wait beats all
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b00100};  // access completes
    vecs[8]  = '{0, 8, 8, 0, 1, 0, 0, 0, 0, 0, 5'b00000};  // not a load
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000};  // mdu op, unit idle
    vecs[10] = '{1, 7, 7, 3, 0, 1, 0, 0, 0, 0, 5'b00000};  // used reg mismatches

    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    cyc = 0; last_start = -1000; scount = 0;

    do_reset();
    chk("reset.cnt", 32'(last_cnt), 32'd0);

    // Combinational table
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      hif.IDEX_MemRead = vecs[i].mr;
      hif.IDEX_rt      = vecs[i].idex_rt;
      hif.IFID_rs      = vecs[i].rs;
      hif.IFID_rt      = vecs[i].rt;
      hif.IFID_use_rs  = vecs[i].use_rs;
      hif.IFID_use_rt  = vecs[i].use_rt;
      hif.IFID_mdu     = vecs[i].mdu;
      hif.EXMEM_MemAcc = vecs[i].macc;
      hif.mem_ready    = vecs[i].mrdy;
      hif.branch_taken = vecs[i].br;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl", i), 32'(last_outs), 32'(vecs[i].exp));
    end

    // MDU: one start pulse, IFID_mdu held -> exactly MDU_LAT stall cycles
    idle_inputs();
    do_reset();
    hif.mdu_start = 1'b1;
    step("mdu.start");
    hif.mdu_start = 1'b0;
    hif.IFID_mdu  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("mdu.busy");
      chk($sformatf("mdu.busy%0d", i), 32'(last_outs), 32'(5'b11010));
    end
    step("mdu.done");
    chk("mdu.release", 32'(last_outs), 32'(5'b00000));

    // MDU start during mem_wait is dropped
    idle_inputs();
    hif.mdu_start    = 1'b1;
    hif.EXMEM_MemAcc = 1'b1;
    step("mdu.memwait");
    chk("mdu.memwait.ctrl", 32'(last_outs), 32'(5'b11001));
    idle_inputs();
    hif.IFID_mdu = 1'b1;
    step("mdu.ignored");
    chk("mdu.ignored.ctrl", 32'(last_outs), 32'(5'b00000));

    // Restart while busy reloads the full latency
    idle_inputs();
    hif.mdu_start = 1'b1;
    step("rs.start0");
    hif.mdu_start = 1'b0;
    step("rs.gap");
    hif.mdu_start = 1'b1;
    step("rs.start1");
    hif.mdu_start = 1'b0;
    hif.IFID_mdu  = 1'b1;
    for (int i = 0; i < 4; i++) step("rs.busy");
    chk("restart.last", 32'(last_outs), 32'(5'b11010));
    step("rs.done");
    chk("restart.release", 32'(last_outs), 32'(5'b00000));

    // mem_wait for 3 cycles over lu and branch, then lu row
    idle_inputs();
    do_reset();
    set_lu(1'b1);
    hif.branch_taken = 1'b1;
    hif.EXMEM_MemAcc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("mw.wait");
      chk($sformatf("mw.wait%0d", i), 32'(last_outs), 32'(5'b11001));
    end
    hif.mem_ready = 1'b1;
    step("mw.ready");
    chk("mw.ready.ctrl", 32'(last_outs), 32'(5'b11010));
    step("mw.cnt");
    chk("mw.cnt", 32'(last_cnt), 32'd4);

    // Reset mid countdown with stall_cycles=7
    idle_inputs();
    do_reset();
    set_lu(1'b1);
    for (int i = 0; i < 6; i++) step("r.lu");
    set_lu(1'b0);
    hif.mdu_start = 1'b1;
    step("r.start");
    hif.mdu_start = 1'b0;
    hif.IFID_mdu  = 1'b1;
    step("r.stall");
    set_lu(1'b1);
    rst_n = 1'b0;
    step("r.inrst");
    chk("r.inrst.ctrl", 32'(last_outs), 32'(5'b00000));
    chk("r.inrst.cnt", 32'(last_cnt), 32'd7);
    rst_n = 1'b1;
    set_lu(1'b0);
    step("r.after");
    chk("r.after.ctrl", 32'(last_outs), 32'(5'b00000));
    chk("r.after.cnt", 32'(last_cnt), 32'd0);

    // Saturation of the 4-bit counter
    idle_inputs();
    do_reset();
    set_lu(1'b1);
    for (int i = 0; i < 20; i++) step("sat.lu");
    set_lu(1'b0);
    step("sat.idle");
    chk("sat.cnt4", 32'(last_cnt4), 32'd15);
    chk("sat.cnt16", 32'(last_cnt), 32'd20);
    step("sat.hold");
    chk("sat.hold4", 32'(last_cnt4), 32'd15);

    // Randomised run against the model
    idle_inputs();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n            = ($urandom_range(0, 99) >= 2);
      hif.IDEX_MemRead = 1'($urandom_range(0, 1));
      hif.IDEX_rt      = 5'($urandom_range(0, 3));
      hif.IFID_rs      = 5'($urandom_range(0, 3));
      hif.IFID_rt      = 5'($urandom_range(0, 3));
      hif.IFID_use_rs  = 1'($urandom_range(0, 1));
      hif.IFID_use_rt  = 1'($urandom_range(0, 1));
      hif.IFID_mdu     = 1'($urandom_range(0, 1));
      hif.mdu_start    = ($urandom_range(0, 99) < 15);
      hif.EXMEM_MemAcc = ($urandom_range(0, 99) < 30);
      hif.mem_ready    = 1'($urandom_range(0, 1));
      hif.branch_taken = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
